// File: rtl/pattern_seq_detector_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package pattern_seq_detector_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DETECT = 2'd2
    } state_t;

    localparam int DEF_PAT_MAX = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

endpackage

// File: rtl/pattern_seq_shiftcmp.sv
// History shift register plus masked compare against the programmed pattern.
// match_next reflects the history as it will be after shifting in in_bit.
module pattern_seq_shiftcmp
    import pattern_seq_detector_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               in_bit,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match_next
);

    logic [PAT_MAX-1:0] hist;
    logic [PAT_MAX-1:0] hist_next;
    logic [PAT_MAX-1:0] mask;

    generate
        if (PAT_MAX == 1) begin : g_one
            assign hist_next = in_bit;
        end else begin : g_wide
            assign hist_next = {hist[PAT_MAX-2:0], in_bit};
        end
    endgenerate

    // Only the low len bits take part in the compare.
    for (genvar i = 0; i < PAT_MAX; i++) begin : g_mask
        assign mask[i] = (LEN_W'(i) < len);
    end

    assign match_next = ~|((hist_next ^ pattern) & mask);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= hist_next;
        end
    end

endmodule

// File: rtl/pattern_seq_detector.sv
// Runtime-programmable serial pattern detector: FSM, config latch, saturating
// match counter and registered one-cycle match pulse.
module pattern_seq_detector
    import pattern_seq_detector_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state, state_n;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q, len_sat;
    logic [LEN_W-1:0]   fill_q, fill_n, fill_inc;
    logic               ovl_q;
    logic               accept, fill_done, eval, match_next, hit, restart;

    assign len_sat   = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
    // A same-cycle cfg_load wins over the sample, which is dropped.
    assign accept    = in_valid && !cfg_load && (state != S_IDLE);
    assign fill_inc  = fill_q + LEN_W'(1);
    assign fill_done = (state == S_FILL) && (fill_inc == len_q);
    assign eval      = accept && ((state == S_DETECT) || fill_done);
    assign hit       = eval && match_next;
    assign restart   = hit && !ovl_q;
    assign armed     = (state == S_DETECT);

    pattern_seq_shiftcmp #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_shiftcmp (
        .clk        (clk),
        .reset      (reset),
        .clr        (cfg_load || restart),
        .shift_en   (accept),
        .in_bit     (in_bit),
        .pattern    (pat_q),
        .len        (len_q),
        .match_next (match_next)
    );

    always_comb begin
        state_n = state;
        fill_n  = fill_q;
        if (cfg_load) begin
            fill_n  = '0;
            state_n = (len_sat == '0) ? S_IDLE : S_FILL;
        end else if (accept) begin
            case (state)
                S_FILL: begin
                    if (fill_done) begin
                        // Non-overlapping hit restarts the fill so matched bits are not reused.
                        fill_n  = restart ? '0 : fill_inc;
                        state_n = restart ? S_FILL : S_DETECT;
                    end else begin
                        fill_n = fill_inc;
                    end
                end
                S_DETECT: begin
                    if (restart) begin
                        fill_n  = '0;
                        state_n = S_FILL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            fill_q       <= '0;
            pat_q        <= '0;
            len_q        <= '0;
            ovl_q        <= 1'b0;
            match_count  <= '0;
            seq_detected <= 1'b0;
        end else begin
            state  <= state_n;
            fill_q <= fill_n;
            if (cfg_load) begin
                pat_q        <= cfg_pattern;
                len_q        <= len_sat;
                ovl_q        <= cfg_overlap;
                match_count  <= '0;
                seq_detected <= 1'b0;
            end else begin
                seq_detected <= hit;
                if (hit && (match_count != CNT_MAX)) begin
                    match_count <= match_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed bench for pattern_seq_detector; expected pulses flow through a scoreboard queue.
module tb_pattern_seq_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_valid;
    logic       in_bit;
    logic       seq_a, armed_a, seq_b, armed_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int   errors = 0;
    int   checks = 0;
    int   stepn  = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    pattern_seq_detector #(.PAT_MAX(8), .LEN_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .seq_detected(seq_a), .match_count(cnt_a), .armed(armed_a)
    );

    pattern_seq_detector #(.PAT_MAX(8), .LEN_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .seq_detected(seq_b), .match_count(cnt_b), .armed(armed_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input; the expected pulse is queued now and popped after the edge.
    task automatic step(input logic v, input logic b, input logic e);
        logic e_pop;
        in_valid = v;
        in_bit   = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        stepn++;
        e_pop = exp_q.pop_front();
        check($sformatf("pulse_a@%0d", stepn), {31'd0, seq_a}, {31'd0, e_pop});
        check($sformatf("pulse_b@%0d", stepn), {31'd0, seq_b}, {31'd0, e_pop});
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic v, input logic b);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        step(v, b, 1'b0);
        cfg_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse", {31'd0, seq_a}, 0);
        check("rst_count", {24'd0, cnt_a}, 0);
        check("rst_armed", {31'd0, armed_a}, 0);
        reset = 1'b0;

        // Unconfigured: samples ignored
        step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
        check("idle_count", {24'd0, cnt_a}, 0);
        check("idle_armed", {31'd0, armed_a}, 0);

        // 1: overlapping 0110
        load(8'b0110, 4'd4, 1'b1, 0, 0);
        check("t1_armed_fill", {31'd0, armed_a}, 0);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        check("t1_armed_pre", {31'd0, armed_a}, 0);
        step(1, 0, 1);
        check("t1_armed_post", {31'd0, armed_a}, 1);
        step(1, 1, 0); step(1, 1, 0); step(1, 0, 1);
        check("t1_count", {24'd0, cnt_a}, 2);

        // 2: non-overlapping 0110
        load(8'b0110, 4'd4, 1'b0, 0, 0);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 1);
        check("t2_armed_0", {31'd0, armed_a}, 0);
        step(1, 1, 0);
        check("t2_armed_1", {31'd0, armed_a}, 0);
        step(1, 1, 0);
        check("t2_armed_2", {31'd0, armed_a}, 0);
        step(1, 0, 0);
        check("t2_armed_3", {31'd0, armed_a}, 0);
        step(1, 1, 0);
        check("t2_armed_4", {31'd0, armed_a}, 1);
        check("t2_count", {24'd0, cnt_a}, 1);

        // 3: len 8 with an in_valid gap
        load(8'b01101101, 4'd8, 1'b1, 0, 0);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
        check("t3_gap_armed", {31'd0, armed_a}, 0);
        check("t3_gap_count", {24'd0, cnt_a}, 0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 1);
        check("t3_count", {24'd0, cnt_a}, 1);

        // 4: len 1 non-overlap, counter saturation on the narrow instance
        load(8'b1, 4'd1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1);
        check("t4_count_a", {24'd0, cnt_a}, 6);
        check("t4_count_b", {30'd0, cnt_b}, 3);
        check("t4_armed_fill", {31'd0, armed_a}, 0);
        step(1, 0, 0);
        check("t4_armed_det", {31'd0, armed_a}, 1);

        // 5: cfg_load with same-cycle valid sample drops the sample
        step(1, 1, 1);
        check("t5_count_pre", {24'd0, cnt_a}, 7);
        load(8'b101, 4'd3, 1'b1, 1, 1);
        check("t5_count_a", {24'd0, cnt_a}, 0);
        check("t5_count_b", {30'd0, cnt_b}, 0);
        step(1, 0, 0); step(1, 1, 0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 1);
        check("t5_count", {24'd0, cnt_a}, 1);

        // 6: reset on the completing sample
        step(1, 1, 0); step(1, 0, 0);
        reset = 1'b1;
        step(1, 1, 0);
        reset = 1'b0;
        check("t6_count", {24'd0, cnt_a}, 0);
        check("t6_armed", {31'd0, armed_a}, 0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        check("t6_ignored", {24'd0, cnt_a}, 0);

        // Oversized length clamps to 8
        load(8'hFF, 4'd15, 1'b1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 0);
        step(1, 1, 1);
        check("clamp_armed", {31'd0, armed_a}, 1);
        check("clamp_count", {24'd0, cnt_a}, 1);

        // len 0 disables detection
        load(8'hFF, 4'd0, 1'b1, 0, 0);
        step(1, 1, 0); step(1, 1, 0);
        check("len0_armed", {31'd0, armed_a}, 0);
        check("len0_count", {24'd0, cnt_a}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
